// File: rtl/mproc_sequencer.sv
// mproc fetch/decode/execute/writeback controller.
// Drives ir/pc/reg_alu strobes and retires instructions.
module mproc_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic             cout,
  input  logic [15:0]      cur_ins,
  output logic             load_ir,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             wr_reg,
  output logic [1:0]       op,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  output logic [2:0]       wr_addr,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] ins_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       wait_q;
  logic             taken_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0] cls;
  logic       is_alu;
  logic       is_jc;
  logic       is_nop;
  logic       is_halt;

  assign cls     = cur_ins[15:11];
  assign is_alu  = (cls == 5'b00000);
  assign is_jc   = (cls == 5'b00001);
  assign is_nop  = (cls == 5'b00010);
  assign is_halt = (cls == 5'b11111);

  assign op        = cur_ins[10:9];
  assign wr_addr   = cur_ins[8:6];
  assign rd_addr_b = cur_ins[5:3];
  assign rd_addr_a = cur_ins[2:0];

  // Strobes decode from the state register so reset kills them at once.
  assign load_ir = (state_q == S_FETCH) & mem_ready;
  assign pc_load = (state_q == S_EXEC) & is_jc & cout;
  assign wr_reg  = (state_q == S_WB) & is_alu;
  assign pc_inc  = (state_q == S_WB) &
                   (is_alu | is_nop | (is_jc & ~taken_q));
  assign halted    = (state_q == S_HALT);
  assign bus_err   = (state_q == S_ERR);
  assign ins_count = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            is_alu,
            is_jc:   state_q <= S_EXEC;
            is_nop:  state_q <= S_WB;
            is_halt: state_q <= S_HALT;
            default: state_q <= S_ERR;
          endcase
        end
        S_EXEC: begin
          taken_q <= is_jc & cout;
          state_q <= S_WB;
        end
        S_WB: begin
          if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
          state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT,
        S_ERR: begin
          state_q <= state_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mproc_sequencer.sv
// Bench for mproc_sequencer: directed table, random instruction
// stream against an instruction-level model, and corner sequences.
module tb_mproc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic        cout = 1'b0;
  logic [15:0] d_in = '0;
  logic [15:0] ir, ir4;

  logic        load_ir, pc_inc, pc_load, wr_reg, halted, bus_err;
  logic [1:0]  op;
  logic [2:0]  rd_a, rd_b, wr_addr;
  logic [15:0] cnt;

  logic        load_ir4, pc_inc4, pc_load4, wr_reg4, halted4, bus_err4;
  logic [1:0]  op4;
  logic [2:0]  rd_a4, rd_b4, wr_addr4;
  logic [3:0]  cnt4;

  int npass = 0;
  int ntot  = 0;
  int mcnt  = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ir <= '0;
    else if (load_ir) ir <= d_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ir4 <= '0;
    else if (load_ir4) ir4 <= d_in;
  end

  mproc_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_ready(mem_ready), .cout(cout), .cur_ins(ir),
    .load_ir(load_ir), .pc_inc(pc_inc), .pc_load(pc_load),
    .wr_reg(wr_reg), .op(op), .rd_addr_a(rd_a),
    .rd_addr_b(rd_b), .wr_addr(wr_addr), .halted(halted),
    .bus_err(bus_err), .ins_count(cnt)
  );

  mproc_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run),
    .mem_ready(mem_ready), .cout(cout), .cur_ins(ir4),
    .load_ir(load_ir4), .pc_inc(pc_inc4), .pc_load(pc_load4),
    .wr_reg(wr_reg4), .op(op4), .rd_addr_a(rd_a4),
    .rd_addr_b(rd_b4), .wr_addr(wr_addr4), .halted(halted4),
    .bus_err(bus_err4), .ins_count(cnt4)
  );

  typedef struct {
    logic [15:0] ins;
    logic        c;
    int          waits;
    int          lat;
    logic        wr;
    logic        inc;
    logic        ld;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp4();
    return (mcnt > 15) ? 16'd15 : 16'(mcnt);
  endfunction

  task automatic check_cycle(string tag, logic li, logic pi,
                             logic pl, logic wr, logic h, logic e);
    chk(tag, {8'b0, load_ir, pc_inc, pc_load, wr_reg,
              load_ir4, pc_inc4, pc_load4, wr_reg4},
        {8'b0, li, pi, pl, wr, li, pi, pl, wr});
    chk({tag, " status"}, {12'b0, halted, bus_err, halted4, bus_err4},
        {12'b0, h, e, h, e});
    chk({tag, " count"}, cnt, mcnt[15:0]);
    chk({tag, " count4"}, {12'b0, cnt4}, exp4());
  endtask

  // Instruction-level model: latency and strobe outcome per class.
  function automatic vec_t ref_model(logic [15:0] ins, logic c, int w);
    vec_t v;
    v.ins = ins; v.c = c; v.waits = w;
    v.lat = 4; v.wr = 1'b0; v.inc = 1'b1; v.ld = 1'b0;
    case (ins[15:11])
      5'd0: v.wr = 1'b1;
      5'd1: begin v.inc = ~c; v.ld = c; end
      default: v.lat = 3;
    endcase
    return v;
  endfunction

  // mode 0: normal, 1: drop run from EXEC, 2: reset during WB
  task automatic do_ins(vec_t v, int mode);
    logic wb, ex;
    d_in = v.ins;
    for (int i = 0; i < v.waits; i++) begin
      mem_ready = 1'b0;
      cout = 1'($urandom);
      #1;
      check_cycle("fetch wait", 0, 0, 0, 0, 0, 0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    check_cycle("fetch", 1, 0, 0, 0, 0, 0);
    cyc();
    for (int k = 1; k < v.lat; k++) begin
      wb = (k == v.lat - 1);
      ex = (k == 2) && (v.lat == 4);
      mem_ready = 1'($urandom);
      d_in = 16'($urandom);
      cout = ex ? v.c : 1'($urandom);
      if (mode == 1 && k >= 2) run = 1'b0;
      #1;
      check_cycle(wb ? "wb" : (ex ? "exec" : "decode"),
                  0, wb & v.inc, ex & v.ld, wb & v.wr, 0, 0);
      if (wb) begin
        chk("fields", {5'b0, op, wr_addr, rd_b, rd_a},
            {5'b0, v.ins[10:0]});
        chk("fields4", {5'b0, op4, wr_addr4, rd_b4, rd_a4},
            {5'b0, v.ins[10:0]});
      end
      if (wb && mode == 2) begin
        reset = 1'b0;
        mcnt = 0;
        #1;
        check_cycle("reset in wb", 0, 0, 0, 0, 0, 0);
        return;
      end
      cyc();
      if (wb) mcnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    cout = 1'b0;
    mcnt = 0;
    #1;
    check_cycle("reset", 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic start_run();
    run = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    check_cycle("idle start", 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic stuck(logic [15:0] ins, logic h, logic e);
    d_in = ins;
    mem_ready = 1'b1;
    #1;
    check_cycle("stuck fetch", 1, 0, 0, 0, 0, 0);
    cyc();
    mem_ready = 1'($urandom);
    #1;
    check_cycle("stuck decode", 0, 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      run = 1'($urandom);
      cout = 1'($urandom);
      #1;
      check_cycle(h ? "halt" : "err", 0, 0, 0, 0, h, e);
      cyc();
    end
  endtask

  initial begin
    vec_t v;
    logic [4:0] cls;
    int w;
    tbl[0] = '{16'h0559, 1'b0, 0,  4, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{16'h0842, 1'b1, 0,  4, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{16'h0842, 1'b0, 0,  4, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h1000, 1'b0, 0,  3, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0559, 1'b0, 14, 4, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h07FF, 1'b1, 2,  4, 1'b1, 1'b1, 1'b0};

    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run = 1'b0;
      mem_ready = 1'b1;
      #1;
      check_cycle("idle", 0, 0, 0, 0, 0, 0);
      cyc();
    end
    start_run();
    foreach (tbl[i]) do_ins(tbl[i], 0);

    for (int n = 0; n < 60; n++) begin
      cls = 5'($urandom_range(0, 2));
      w = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      v = ref_model({cls, 11'($urandom)}, 1'($urandom), w);
      do_ins(v, 0);
    end

    v = ref_model(16'h0559, 1'b0, 1);
    do_ins(v, 1);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      #1;
      check_cycle("idle after drop", 0, 0, 0, 0, 0, 0);
      cyc();
    end
    start_run();

    v = ref_model(16'h0559, 1'b0, 0);
    do_ins(v, 2);
    cyc();
    reset = 1'b1;
    start_run();

    for (int n = 0; n < 20; n++) begin
      v = ref_model(16'h1000 | 16'(n), 1'b0, 0);
      do_ins(v, 0);
    end

    stuck(16'hF800, 1'b1, 1'b0);
    do_reset();
    start_run();
    stuck(16'h3000, 1'b0, 1'b1);
    do_reset();
    start_run();

    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0;
      #1;
      check_cycle("timeout wait", 0, 0, 0, 0, 0, 0);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      check_cycle("timeout err", 0, 0, 0, 0, 0, 1);
      cyc();
    end
    do_reset();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
